// File: rtl/seq_control_unit_if.sv
// Instruction and memory handshake bundle for seq_control_unit.
// The master side issues instructions and answers memory requests; the slave side is the sequencer.
interface seq_control_unit_if #(
    parameter int INSTR_W     = 10,
    parameter int OPCODE_W    = 4,
    parameter int FIELD_W     = 4,
    parameter int STACK_DEPTH = 8
);
    localparam int IMM_W = INSTR_W - OPCODE_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    logic                instr_valid;
    logic [INSTR_W-1:0]  instr;
    logic                instr_ready;
    logic                alu_zero;
    logic                mem_ack;
    logic                mem_req;
    logic                mem_we;
    logic                reg_we;
    logic [FIELD_W-1:0]  reg_sel;
    logic [IMM_W-1:0]    imm_out;
    logic [OPCODE_W-1:0] alu_op;
    logic                pc_inc;
    logic                pc_load;
    logic [SP_W-1:0]     sp;
    logic                flag;
    logic                err_overflow;
    logic                err_underflow;
    logic                err_illegal;
    logic                err_timeout;

    modport master (
        output instr_valid, instr, alu_zero, mem_ack,
        input  instr_ready, mem_req, mem_we, reg_we, reg_sel, imm_out, alu_op,
               pc_inc, pc_load, sp, flag,
               err_overflow, err_underflow, err_illegal, err_timeout
    );

    modport slave (
        input  instr_valid, instr, alu_zero, mem_ack,
        output instr_ready, mem_req, mem_we, reg_we, reg_sel, imm_out, alu_op,
               pc_inc, pc_load, sp, flag,
               err_overflow, err_underflow, err_illegal, err_timeout
    );
endinterface

// File: rtl/seq_control_unit.sv
// Multi-cycle control sequencer: accepts one instruction per handshake and walks it
// through DECODE/EXEC/MEM/WB, owning the compare flag, skip logic, stack pointer and sticky errors.
module seq_control_unit #(
    parameter int INSTR_W     = 10,
    parameter int OPCODE_W    = 4,
    parameter int FIELD_W     = 4,
    parameter int STACK_DEPTH = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input logic             clk,
    input logic             rst,
    seq_control_unit_if.slave bus
);
    localparam int IMM_W  = INSTR_W - OPCODE_W;
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPCODE_W-1:0] OP_RESULT       = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SET_IMM      = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LOAD_QUERY   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_COMPARE      = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_JUMP_BACK    = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_INCREMENT    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_IF_DONE      = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_STORE_ZERO   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_SET_ARG      = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_JUMP_FP      = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_SKIP_NOT_ONE = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_PUSH         = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_POP          = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_SET_TEMP     = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_RETURN       = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_FIRST_ILLEGAL = OPCODE_W'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LOAD_QUERY) || (op == OP_STORE_ZERO) || (op == OP_PUSH) ||
               (op == OP_POP) || (op == OP_RETURN);
    endfunction

    function automatic logic is_mem_write(input logic [OPCODE_W-1:0] op);
        return (op == OP_STORE_ZERO) || (op == OP_PUSH);
    endfunction

    function automatic logic writes_reg(input logic [OPCODE_W-1:0] op);
        return (op == OP_RESULT) || (op == OP_SET_IMM) || (op == OP_LOAD_QUERY) ||
               (op == OP_INCREMENT) || (op == OP_SET_ARG) || (op == OP_POP) ||
               (op == OP_SET_TEMP);
    endfunction

    function automatic logic loads_pc(input logic [OPCODE_W-1:0] op, input logic cond);
        return (op == OP_JUMP_BACK) || (op == OP_JUMP_FP) || (op == OP_RETURN) ||
               ((op == OP_IF_DONE) && cond);
    endfunction

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [OPCODE_W-1:0]  opcode_q, opcode_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [IMM_W-1:0]     imm_q, imm_d;
    logic [SP_W-1:0]      sp_q, sp_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 flag_q, flag_d;
    logic                 skip_q, skip_d;
    logic                 mem_we_q, mem_we_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 err_underflow_q, err_underflow_d;
    logic                 err_illegal_q, err_illegal_d;
    logic                 err_timeout_q, err_timeout_d;

    logic [OPCODE_W-1:0]  dec_opcode;
    logic                 wb_pc_load;

    assign dec_opcode = instr_q[INSTR_W-1 -: OPCODE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            instr_q         <= '0;
            opcode_q        <= '0;
            field_q         <= '0;
            imm_q           <= '0;
            sp_q            <= '0;
            wait_q          <= '0;
            flag_q          <= 1'b0;
            skip_q          <= 1'b0;
            mem_we_q        <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_illegal_q   <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            opcode_q        <= opcode_d;
            field_q         <= field_d;
            imm_q           <= imm_d;
            sp_q            <= sp_d;
            wait_q          <= wait_d;
            flag_q          <= flag_d;
            skip_q          <= skip_d;
            mem_we_q        <= mem_we_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
            err_illegal_q   <= err_illegal_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        opcode_d        = opcode_q;
        field_d         = field_q;
        imm_d           = imm_q;
        sp_d            = sp_q;
        wait_d          = wait_q;
        flag_d          = flag_q;
        skip_d          = skip_q;
        mem_we_d        = mem_we_q;
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;
        err_illegal_d   = err_illegal_q;
        err_timeout_d   = err_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                opcode_d = dec_opcode;
                field_d  = instr_q[INSTR_W-OPCODE_W-1 -: FIELD_W];
                imm_d    = instr_q[IMM_W-1:0];
                // A pending skip squashes this instruction before it can raise any error.
                if (skip_q) begin
                    skip_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (dec_opcode >= OP_FIRST_ILLEGAL) begin
                    err_illegal_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                wait_d   = '0;
                mem_we_d = 1'b0;
                if (opcode_q == OP_COMPARE) begin
                    flag_d = bus.alu_zero;
                end
                if (opcode_q == OP_SKIP_NOT_ONE) begin
                    skip_d = ~flag_q;
                end
                if (is_mem_op(opcode_q)) begin
                    if ((opcode_q == OP_PUSH) && (sp_q == SP_W'(STACK_DEPTH))) begin
                        err_overflow_d = 1'b1;
                        state_d        = S_IDLE;
                    end else if (((opcode_q == OP_POP) || (opcode_q == OP_RETURN)) &&
                                 (sp_q == '0)) begin
                        err_underflow_d = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        mem_we_d = is_mem_write(opcode_q);
                        state_d  = S_MEM;
                    end
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                // wait_q counts completed MEM cycles without an acknowledge.
                if (bus.mem_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                if (opcode_q == OP_PUSH) begin
                    sp_d = sp_q + SP_W'(1);
                end else if ((opcode_q == OP_POP) || (opcode_q == OP_RETURN)) begin
                    sp_d = sp_q - SP_W'(1);
                end
                state_d = S_IDLE;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wb_pc_load = (state_q == S_WB) && loads_pc(opcode_q, flag_q);

    assign bus.instr_ready   = (state_q == S_IDLE);
    assign bus.mem_req       = (state_q == S_MEM);
    assign bus.mem_we        = (state_q == S_MEM) && mem_we_q;
    assign bus.reg_we        = (state_q == S_WB) && writes_reg(opcode_q);
    assign bus.pc_load       = wb_pc_load;
    assign bus.pc_inc        = (state_q == S_WB) && !wb_pc_load;
    assign bus.reg_sel       = field_q;
    assign bus.imm_out       = imm_q;
    assign bus.alu_op        = opcode_q;
    assign bus.sp            = sp_q;
    assign bus.flag          = flag_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.err_underflow = err_underflow_q;
    assign bus.err_illegal   = err_illegal_q;
    assign bus.err_timeout   = err_timeout_q;
endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
- Multi-cycle, parametrised successor to the combinational opcode decoder of the 10-bit processor.
- Accepts one instruction per valid/ready handshake and splits it into fields by parameter widths.
- Sequences it through DECODE/EXEC/MEM/WB states, producing one-cycle control strobes.
- Owns the compare flag, skip/squash logic, a bounded stack-pointer counter, a memory-handshake timeout and sticky error reporting.

Parameters:
- INSTR_W, 10, instruction width.
- OPCODE_W, 4, opcode width; opcode = instr[INSTR_W-1 -: OPCODE_W].
- FIELD_W, 4, register-select width; field = instr[INSTR_W-OPCODE_W-1 -: FIELD_W].
- STACK_DEPTH, 8, maximum stack entries; sp width = clog2(STACK_DEPTH+1).
- MEM_TIMEOUT, 15, maximum cycles in MEM waiting for mem_ack.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  INSTR_W  instruction word.
- instr_ready  out  1  high only in IDLE.
- alu_zero  in  1  ALU zero result, sampled in EXEC of compare.
- mem_ack  in  1  memory completion.
- mem_req  out  1  memory request, held through MEM.
- mem_we  out  1  write qualifier for mem_req.
- reg_we  out  1  register-file write strobe (WB).
- reg_sel  out  FIELD_W  register index, valid with reg_we/mem_req.
- imm_out  out  INSTR_W-OPCODE_W  zero-extended low field.
- alu_op  out  OPCODE_W  opcode of the instruction in flight.
- pc_inc  out  1  PC increment strobe (WB).
- pc_load  out  1  PC load strobe (WB).
- sp  out  clog2(STACK_DEPTH+1)  stack pointer.
- flag  out  1  compare flag.
- err_overflow, err_underflow, err_illegal, err_timeout  out  1 each  sticky errors.

Behaviour:
- States: IDLE, DECODE, EXEC, MEM, WB, HALT.
- Reset (async, any state, including mid-MEM):
  - state=IDLE, sp=0, flag=0, skip_pending=0.
  - All strobes, mem_req, mem_we and errors = 0; reg_sel, imm_out and alu_op = 0.
- IDLE: instr_ready=1. When instr_valid is high at the edge, latch instr and go to DECODE.
- DECODE (1 cycle): register the fields.
  - If skip_pending=1: clear it, go to IDLE, no strobes, pc_inc=0 (the instruction is squashed).
  - Else if opcode >= 15: err_illegal=1, go to HALT.
  - Else go to EXEC.
- EXEC (1 cycle):
  - Memory ops go to MEM: loadQuery(2) read, storeToZero(7) write, push(11) write, pop(12) read, return(14) read.
  - All other opcodes go to WB.
  - compare(3): flag <= alu_zero.
  - skipIfNotOne(10): skip_pending <= ~flag.
- Stack bounds, checked in EXEC:
  - push with sp==STACK_DEPTH: err_overflow=1, go to IDLE, no mem_req, sp unchanged.
  - pop/return with sp==0: err_underflow=1, go to IDLE, sp unchanged.
- MEM:
  - mem_req=1 (asserted the cycle after the EXEC edge); mem_we=1 for writes.
  - On mem_ack=1 at the edge, go to WB.
  - Wait counter starts at 0 on MEM entry. If MEM_TIMEOUT cycles elapse without ack: err_timeout=1, go to HALT, drop mem_req.
- WB (1 cycle): strobes high for exactly this cycle, then go to IDLE.
  - pc_inc=1 unless pc_load=1.
  - pc_load=1 for jumpBackOrInit(4), jumpOrInitFp(9), return(14), and for ifDone(6) when flag=1.
  - reg_we=1 for setImmediate(1), loadQuery(2), increment(5), setArg(8), pop(12), setTemp(13), result(0).
  - sp: +1 for push, -1 for pop/return, updated at the WB->IDLE edge.
- Latency: accept edge E0; WB cycle follows E2 (non-memory) or E(2+n+1) for memory ops with ack after n MEM cycles. Minimum 4 cycles per instruction.
- HALT: instr_ready=0, all strobes 0. Exit by reset only.
- Errors stay set until reset. Multiple errors may be set.
- instr_valid outside IDLE is ignored. instr is sampled only at the accept edge.

Test Plan:
- Reset, then setImmediate (instr=10'b0001_0011_01): ready at E0; reg_we=1, reg_sel=3, imm_out=6'h0D, pc_inc=1 exactly in cycle after E2; ready again after E3.
- push with mem_ack delayed 3 cycles: mem_req=1, mem_we=1 held 3 cycles; WB pulse follows; sp 0->1. Repeat to sp=8, then push again -> err_overflow=1, no mem_req, sp=8.
- pop with sp=0 -> err_underflow=1, no mem_req, sp stays 0. Push then return -> pc_load=1, pc_inc=0, sp back to 0.
- compare with alu_zero=0, then skipIfNotOne, then setImmediate -> setImmediate squashed (no reg_we/pc_inc). Repeat with alu_zero=1 -> executes normally.
- opcode 4'hF -> err_illegal=1, HALT, instr_ready=0 indefinitely. loadQuery with no ack -> after 15 MEM cycles err_timeout=1, mem_req=0, HALT.
- Assert rst during MEM with mem_req=1 -> mem_req falls without waiting for a clock edge. All outputs are at reset values; the next instruction is accepted normally.
